seg_scan_controller: RTL

Time-multiplexed scan controller that shares one 7-segment decoder and one segment bus among NUM_DIGITS digit sources. It sits between counter/BCD datapaths and the board's common-anode display. It sequences digit anodes with a programmable dwell time and dead-time blanking, and decodes each digit with the team's standard active-low segment encoding.

---
 rtl/seg_scan_controller.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/seg_scan_controller.sv
// rtl/seg_scan_controller.sv - time-multiplexed 7-segment scan controller, active-low outputs.
// Optional SEG_LEADING_ZERO_BLANK_EN blanks leading zero digits above digit 0.
module seg_scan_controller #(
    parameter int NUM_DIGITS   = 4,
    parameter int DIGIT_CYCLES = 100000,
    parameter int DEAD_CYCLES  = 2
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            en,
    input  logic [4*NUM_DIGITS-1:0]         iDigits,
    input  logic [NUM_DIGITS-1:0]           iDp,
    output logic [NUM_DIGITS-1:0]           oAn,
    output logic [6:0]                      oSeg,
    output logic                            oDp,
    output logic [$clog2(NUM_DIGITS)-1:0]   oSel,
    output logic                            oFrame
);

    localparam int SW     = $clog2(NUM_DIGITS);
    localparam int LP_MAX = (DIGIT_CYCLES > DEAD_CYCLES)
                          ? ((DIGIT_CYCLES > 2) ? DIGIT_CYCLES : 2)
                          : ((DEAD_CYCLES > 2) ? DEAD_CYCLES : 2);
    localparam int CW     = $clog2(LP_MAX);
    localparam logic [CW-1:0] LP_DRIVE_LAST = CW'(DIGIT_CYCLES - 1);
    localparam logic [CW-1:0] LP_DEAD_LAST  = CW'((DEAD_CYCLES == 0) ? 0 : DEAD_CYCLES - 1);
    localparam logic [SW-1:0] LP_SEL_LAST   = SW'(NUM_DIGITS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRIVE = 2'd1,
        S_BLANK = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [CW-1:0]         r_cnt;
    logic [CW-1:0]         w_cnt_nxt;
    logic [SW-1:0]         r_sel;
    logic [SW-1:0]         w_sel_nxt;
    logic [SW-1:0]         w_sel_inc;
    logic                  r_frame;
    logic                  w_frame_nxt;
    logic [NUM_DIGITS-1:0] r_an;
    logic [NUM_DIGITS-1:0] w_an_nxt;
    logic [6:0]            r_seg;
    logic [6:0]            w_seg_nxt;
    logic                  r_dp;
    logic                  w_dp_nxt;
    logic [3:0]            w_digit;
    logic                  w_lz_blank;

    function automatic logic [6:0] f_decode(input logic [3:0] d);
        case (d)
            4'd0:    f_decode = 7'b1000000;
            4'd1:    f_decode = 7'b1111001;
            4'd2:    f_decode = 7'b0100100;
            4'd3:    f_decode = 7'b0110000;
            4'd4:    f_decode = 7'b0011001;
            4'd5:    f_decode = 7'b0010010;
            4'd6:    f_decode = 7'b0000010;
            4'd7:    f_decode = 7'b1111000;
            4'd8:    f_decode = 7'b0000000;
            4'd9:    f_decode = 7'b0010000;
            default: f_decode = 7'b1111111;
        endcase
    endfunction

    assign w_sel_inc = (r_sel == LP_SEL_LAST) ? '0 : r_sel + 1'b1;
    assign w_digit   = iDigits[{w_sel_nxt, 2'b00} +: 4];

`ifdef SEG_LEADING_ZERO_BLANK_EN
    // Digits sel..top shifted down to bit 0; all-zero means this digit is a leading zero.
    assign w_lz_blank = (w_sel_nxt != '0) && ((iDigits >> {w_sel_nxt, 2'b00}) == '0);
`else
    assign w_lz_blank = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + 1'b1;
        w_sel_nxt   = r_sel;
        case (r_state)
            S_IDLE: begin
                w_cnt_nxt = '0;
                w_sel_nxt = '0;
                if (en) begin
                    w_state_nxt = S_DRIVE;
                end
            end
            S_DRIVE: begin
                if (r_cnt == LP_DRIVE_LAST) begin
                    w_cnt_nxt   = '0;
                    w_sel_nxt   = w_sel_inc;
                    w_state_nxt = (DEAD_CYCLES == 0) ? S_DRIVE : S_BLANK;
                end
            end
            S_BLANK: begin
                if (r_cnt == LP_DEAD_LAST) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_DRIVE;
                end
            end
            default: begin
                w_cnt_nxt   = '0;
                w_sel_nxt   = '0;
                w_state_nxt = S_IDLE;
            end
        endcase
        if (!en) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
            w_sel_nxt   = '0;
        end

        // A frame starts whenever digit 0 is freshly entered, not while it keeps dwelling.
        w_frame_nxt = (w_state_nxt == S_DRIVE) && (w_sel_nxt == '0)
                   && !((r_state == S_DRIVE) && (r_sel == '0));

        w_an_nxt  = '1;
        w_seg_nxt = 7'h7F;
        w_dp_nxt  = 1'b1;
        if (w_state_nxt == S_DRIVE) begin
            w_an_nxt  = ~(NUM_DIGITS'(1) << w_sel_nxt);
            w_seg_nxt = w_lz_blank ? 7'h7F : f_decode(w_digit);
            w_dp_nxt  = ~iDp[w_sel_nxt];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_sel   <= '0;
            r_frame <= 1'b0;
            r_an    <= '1;
            r_seg   <= 7'h7F;
            r_dp    <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_sel   <= w_sel_nxt;
            r_frame <= w_frame_nxt;
            r_an    <= w_an_nxt;
            r_seg   <= w_seg_nxt;
            r_dp    <= w_dp_nxt;
        end
    end

    assign oAn    = r_an;
    assign oSeg   = r_seg;
    assign oDp    = r_dp;
    assign oSel   = r_sel;
    assign oFrame = r_frame;

endmodule
